// File: rtl/matrix_pkg.sv
// Shared sizing constants and sequencer state encoding for the matrix compute path.
package matrix_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int MAT_WORDS = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_skid_buf.sv
// Two-entry FIFO used as a skid buffer between a fixed-latency source and a stallable sink.
module seq_skid_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Pointers and occupancy; flush discards contents in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr] <= din;
  end

  assign head  = mem_q[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Sequences one pass of the PE over the matrix buffer: read, stream with row markers, write back.
module matrix_seq_ctrl #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int ADDR_W = matrix_pkg::ADDR_W,
  parameter int ROWS   = matrix_pkg::ROWS,
  parameter int COLS   = matrix_pkg::COLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic              pe_in_valid,
  output logic [DATA_W-1:0] pe_in_data,
  output logic              pe_in_last,
  input  logic              pe_in_ready,
  input  logic              pe_out_valid,
  input  logic [DATA_W-1:0] pe_out_data,
  output logic              pe_out_ready,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data,
  output logic [3:0]        row_idx
);
  import matrix_pkg::*;

  localparam int              CW   = $clog2(COLS);
  localparam logic [ADDR_W:0] TERM = (ADDR_W+1)'(ROWS * COLS);

  seq_state_t        state, state_nxt;
  logic [ADDR_W:0]   rd_cnt, in_cnt, out_cnt;
  logic [ADDR_W:0]   rd_cnt_nxt, in_cnt_nxt, out_cnt_nxt;
  logic              rd_vld_p1;
  logic              active, fire_in, fire_out;
  logic              skid_push, skid_pop, skid_flush;
  logic              skid_empty, skid_full;
  logic [1:0]        skid_count;
  logic [DATA_W-1:0] skid_head;
  logic [CW-1:0]     col;

  assign active = (state == RUN) || (state == DRAIN);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Stage p0: read issue, throttled so skid occupancy plus the in-flight read never exceeds two.
  assign in_rd_en   = (state == RUN) && !skid_full &&
                      ((3'(skid_count) + 3'(rd_vld_p1)) < 3'd2);
  assign in_rd_addr = rd_cnt[ADDR_W-1:0];

  // Stage p1: returning data is either handed straight to the PE or parked in the skid buffer.
  assign pe_in_valid = active && (!skid_empty || rd_vld_p1);
  assign pe_in_data  = !pe_in_valid ? '0 : (skid_empty ? in_rd_data : skid_head);
  assign col         = in_cnt[CW-1:0];
  assign pe_in_last  = pe_in_valid && (col == CW'(COLS - 1));
  assign fire_in     = pe_in_valid && pe_in_ready;
  assign skid_pop    = fire_in && !skid_empty;
  assign skid_push   = active && rd_vld_p1 && !(skid_empty && fire_in);
  assign skid_flush  = active && abort;

  seq_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (skid_flush),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (in_rd_data),
    .head  (skid_head),
    .empty (skid_empty),
    .full  (skid_full),
    .count (skid_count)
  );

  assign pe_out_ready = active;
  assign fire_out     = pe_out_valid && pe_out_ready;
  assign out_wr_en    = fire_out;
  assign out_wr_addr  = out_cnt[ADDR_W-1:0];
  assign out_wr_data  = fire_out ? pe_out_data : '0;
  assign row_idx      = busy ? 4'(in_cnt[ADDR_W-1:CW]) : 4'd0;

  assign rd_cnt_nxt  = rd_cnt + (ADDR_W+1)'(in_rd_en);
  assign in_cnt_nxt  = in_cnt + (ADDR_W+1)'(fire_in);
  assign out_cnt_nxt = out_cnt + (ADDR_W+1)'(fire_out);

  // Completion looks at next-cycle counts so the last write and done are back to back.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (rd_cnt_nxt == TERM) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if ((in_cnt_nxt == TERM) && (out_cnt_nxt == TERM)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= in_rd_en;
      if ((state == IDLE) && start && !abort) begin
        rd_cnt  <= '0;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        rd_cnt  <= rd_cnt_nxt;
        in_cnt  <= in_cnt_nxt;
        out_cnt <= out_cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Directed bench for matrix_seq_ctrl with a behavioural input buffer and identity PE.
module tb_matrix_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        in_rd_en;
  logic [7:0]  in_rd_addr;
  logic [15:0] in_rd_data;
  logic        pe_in_valid;
  logic [15:0] pe_in_data;
  logic        pe_in_last;
  logic        pe_in_ready;
  logic        pe_out_valid;
  logic [15:0] pe_out_data;
  logic        pe_out_ready;
  logic        out_wr_en;
  logic [7:0]  out_wr_addr;
  logic [15:0] out_wr_data;
  logic [3:0]  row_idx;

  matrix_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .in_rd_en     (in_rd_en),
    .in_rd_addr   (in_rd_addr),
    .in_rd_data   (in_rd_data),
    .pe_in_valid  (pe_in_valid),
    .pe_in_data   (pe_in_data),
    .pe_in_last   (pe_in_last),
    .pe_in_ready  (pe_in_ready),
    .pe_out_valid (pe_out_valid),
    .pe_out_data  (pe_out_data),
    .pe_out_ready (pe_out_ready),
    .out_wr_en    (out_wr_en),
    .out_wr_addr  (out_wr_addr),
    .out_wr_data  (out_wr_data),
    .row_idx      (row_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [58:0] outs;
  assign outs = {busy, done, in_rd_en, in_rd_addr, pe_in_valid, pe_in_data, pe_in_last,
                 pe_out_ready, out_wr_en, out_wr_addr, out_wr_data, row_idx};

  // Input buffer: word at address a holds a ^ A5A5, one cycle read latency.
  always @(posedge clk) begin
    if (in_rd_en) in_rd_data <= {8'h00, in_rd_addr} ^ 16'hA5A5;
  end

  // PE: identity, either combinational or through a three-register pipeline.
  bit          rnd_rdy   = 1'b0;
  bit          pipe_mode = 1'b0;
  logic [16:0] pipe_q [3];
  always @(posedge clk) begin
    pipe_q[0] <= {pe_in_valid && pe_in_ready, pe_in_data};
    pipe_q[1] <= pipe_q[0];
    pipe_q[2] <= pipe_q[1];
  end
  assign pe_out_valid = pipe_mode ? pipe_q[2][16]   : (pe_in_valid && pe_in_ready);
  assign pe_out_data  = pipe_mode ? pipe_q[2][15:0] : pe_in_data;

  always @(posedge clk) begin
    #1;
    pe_in_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial pe_in_ready = 1'b1;

  // Monitor: sampled on the falling edge, cleared on request from the stimulus.
  bit          clr_req    = 1'b0;
  bit          abort_seen = 1'b0;
  int          abort_cyc  = 0;
  int          wr_cnt, xfer_cnt, rd_cnt_m, last_cnt, done_cnt, mon_err, late_wr;
  bit          prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [15:0] out_mem [256];

  always @(negedge clk) begin
    if (clr_req) begin
      wr_cnt = 0; xfer_cnt = 0; rd_cnt_m = 0; last_cnt = 0;
      done_cnt = 0; mon_err = 0; late_wr = 0; prev_stall = 1'b0;
      for (int i = 0; i < 256; i++) out_mem[i] = 16'h0000;
    end else if (rst_n) begin
      if (in_rd_en) begin
        if (rd_cnt_m - xfer_cnt >= 2) mon_err++;
        if (in_rd_addr != 8'(rd_cnt_m)) mon_err++;
        rd_cnt_m++;
      end
      if (prev_stall && (!pe_in_valid || pe_in_data != prev_data || pe_in_last != prev_last))
        mon_err++;
      if (pe_in_valid && pe_in_ready) begin
        if (pe_in_data != (16'(xfer_cnt) ^ 16'hA5A5)) mon_err++;
        if (pe_in_last != ((xfer_cnt % 16) == 15)) mon_err++;
        if (row_idx != 4'(xfer_cnt / 16)) mon_err++;
        if (pe_in_last) last_cnt++;
        xfer_cnt++;
      end
      prev_stall = pe_in_valid && !pe_in_ready;
      prev_data  = pe_in_data;
      prev_last  = pe_in_last;
      if (out_wr_en) begin
        if (out_wr_addr != 8'(wr_cnt)) mon_err++;
        out_mem[out_wr_addr] = out_wr_data;
        wr_cnt++;
        if (abort_seen && cyc > abort_cyc) late_wr++;
      end
      if (done) done_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1;
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
  endtask

  task automatic run_pass(input bit rnd, input bit pm, input bit inj,
                          input int abort_xfer, input int abort_off,
                          output int t0, output int lat, output int endc, output bit ended);
    bit s10 = 1'b0;
    bit s200 = 1'b0;
    bit ab_done = 1'b0;
    lat = -1;
    ended = 1'b0;
    endc = 0;
    rnd_rdy = rnd;
    pipe_mode = pm;
    abort_seen = 1'b0;
    clear_mon();
    t0 = cyc;
    start = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (done && lat < 0) lat = cyc - t0;
      if (t > 0 && !busy && !done) begin
        ended = 1'b1;
        endc = cyc;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (inj && !s10 && xfer_cnt >= 10) begin start = 1'b1; s10 = 1'b1; end
      else if (inj && !s200 && xfer_cnt >= 200) begin start = 1'b1; s200 = 1'b1; end
      abort = !ab_done && ((abort_xfer >= 0 && xfer_cnt >= abort_xfer) ||
                           (abort_off >= 0 && cyc == t0 + abort_off));
      if (abort) begin
        ab_done = 1'b1;
        abort_seen = 1'b1;
        abort_cyc = cyc;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rnd_rdy = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_full(input string tag, input int t0, input int lat, input int endc,
                            input bit ended, input int exp_lat, input int exp_wr, input int exp_done);
    int derr = 0;
    for (int k = 0; k < 256; k++)
      if (out_mem[k] != (16'(k) ^ 16'hA5A5)) derr++;
    check({tag, "_ended"}, ended, 1);
    check({tag, "_wr_cnt"}, wr_cnt, exp_wr);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_data_err"}, derr, 0);
    check({tag, "_last_cnt"}, last_cnt, 16);
    check({tag, "_xfer_cnt"}, xfer_cnt, 256);
    check({tag, "_mon_err"}, mon_err, 0);
    if (exp_lat >= 0) check({tag, "_done_lat"}, lat, exp_lat);
    check({tag, "_busy_drop"}, endc - (t0 + lat), 1);
  endtask

  typedef struct {
    bit rnd;
    bit pm;
    bit inj;
    int exp_lat;
    int exp_wr;
    int exp_done;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t0, lat, endc, bsy, rde;
    bit ended;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 258, 256, 1};
    vecs[1] = '{1'b1, 1'b1, 1'b0,  -1, 256, 1};
    vecs[2] = '{1'b1, 1'b0, 1'b0,  -1, 256, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 261, 256, 1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 258, 256, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b1,  -1, 256, 1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs", outs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs, 0);

    for (int i = 0; i < 6; i++) begin
      run_pass(vecs[i].rnd, vecs[i].pm, vecs[i].inj, -1, -1, t0, lat, endc, ended);
      check_full($sformatf("vec%0d", i), t0, lat, endc, ended,
                 vecs[i].exp_lat, vecs[i].exp_wr, vecs[i].exp_done);
    end

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    bsy = 0;
    rde = 0;
    repeat (4) begin
      @(negedge clk);
      bsy += busy;
      rde += in_rd_en;
    end
    check("start_abort_idle_busy", bsy, 0);
    check("start_abort_idle_rd", rde, 0);

    // abort after 100 transfers, then a clean pass
    run_pass(1'b0, 1'b0, 1'b0, 100, -1, t0, lat, endc, ended);
    check("abort_ended", ended, 1);
    check("abort_busy_drop", endc - abort_cyc, 1);
    check("abort_no_done", done_cnt, 0);
    check("abort_wr_cnt", wr_cnt, 101);
    check("abort_late_wr", late_wr, 0);
    check("abort_mon_err", mon_err, 0);
    run_pass(1'b0, 1'b0, 1'b0, -1, -1, t0, lat, endc, ended);
    check_full("post_abort", t0, lat, endc, ended, 258, 256, 1);

    // abort during DONE: the pulse still completes
    run_pass(1'b0, 1'b0, 1'b0, -1, 258, t0, lat, endc, ended);
    check_full("abort_in_done", t0, lat, endc, ended, 258, 256, 1);

    // reset while draining results from the pipelined PE
    rnd_rdy = 1'b0;
    pipe_mode = 1'b1;
    clear_mon();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #1;
      if (xfer_cnt == 256) break;
    end
    check("drain_reached", xfer_cnt, 256);
    check("drain_busy", busy, 1);
    check("drain_pending", (wr_cnt < 256), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", outs, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_idle", outs, 0);
    run_pass(1'b0, 1'b1, 1'b0, -1, -1, t0, lat, endc, ended);
    check_full("post_rst", t0, lat, endc, ended, 261, 256, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
